// File: rtl/clock_lock_supervisor.sv
// ----------------------------------------------------------------------------
// clock_lock_supervisor
//
// Supervises the pixel-clock PLL from the free-running board oscillator.
// The asynchronous PLL lock flag is synchronised. Lock must then stay high
// for SETTLE_CYCLES before clk_locked is declared. The downstream reset is
// held for RESET_HOLD cycles after that. If lock is not seen within
// TIMEOUT_CYCLES, the PLL is put back into reset with a PLL_RST_CYCLES-long
// low pulse on its RESETB pin.
//
// Optional feature macro: CLOCK_LOCK_LOSS_COUNT_EN
//   defined   : builds the sticky 'lost' flag and the saturating
//               'loss_count' counter, which clear_loss clears.
//   undefined : 'lost' and 'loss_count' are tied to 0 and clear_loss is
//               ignored. The FSM behaves the same in both builds.
//
// Ports
//   clk         in   free-running clock, independent of the PLL
//   rst         in   synchronous active-high reset
//   pll_locked  in   PLL LOCK output, asynchronous to clk
//   clear_loss  in   single-cycle pulse, clears loss_count and lost
//   pll_resetb  out  PLL RESETB, active low
//   clk_locked  out  lock declared stable (HOLD and RUN)
//   rst_out     out  active-high reset for downstream logic
//   lost        out  sticky: lock was lost after being declared
//   loss_count  out  saturating count of lock losses (CNT_W bits)
// ----------------------------------------------------------------------------
module clock_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int RESET_HOLD     = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int PLL_RST_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             clear_loss,
    output logic             pll_resetb,
    output logic             clk_locked,
    output logic             rst_out,
    output logic             lost,
    output logic [CNT_W-1:0] loss_count
);

    function automatic int f_max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The shared state counter must hold the largest terminal value
    // (limit - 1) of any state.
    localparam int CNT_MAX = f_max2(f_max2(SETTLE_CYCLES, RESET_HOLD),
                                    f_max2(TIMEOUT_CYCLES, PLL_RST_CYCLES));
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] PRST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD - 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_SETTLE,
        S_HOLD,
        S_RUN
    } state_t;

    // Output decode for a state: {pll_resetb, clk_locked, rst_out}.
    function automatic logic [2:0] f_outs(input state_t s);
        case (s)
            S_PLL_RST: return 3'b001;
            S_HOLD:    return 3'b111;
            S_RUN:     return 3'b110;
            default:   return 3'b101;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_pll_resetb;
    logic                   r_clk_locked;
    logic                   r_rst_out;
    logic                   w_lock_s;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // Every transition zeroes the counter and loads the outputs of the new
    // state, so the outputs change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_state <= S_PLL_RST;
            r_cnt   <= '0;
            {r_pll_resetb, r_clk_locked, r_rst_out} <= f_outs(S_PLL_RST);
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
            r_cnt  <= r_cnt + CW'(1);
            case (r_state)
                S_PLL_RST: begin
                    // The lock flag is meaningless while the PLL is held in reset.
                    if (r_cnt == PRST_LAST) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                        {r_pll_resetb, r_clk_locked, r_rst_out} <= f_outs(S_WAIT_LOCK);
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock takes priority over a coincident timeout.
                    if (w_lock_s) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= '0;
                        {r_pll_resetb, r_clk_locked, r_rst_out} <= f_outs(S_SETTLE);
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_state <= S_PLL_RST;
                        r_cnt   <= '0;
                        {r_pll_resetb, r_clk_locked, r_rst_out} <= f_outs(S_PLL_RST);
                    end
                end
                S_SETTLE: begin
                    if (!w_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                        {r_pll_resetb, r_clk_locked, r_rst_out} <= f_outs(S_WAIT_LOCK);
                    end else if (r_cnt == SETTLE_LAST) begin
                        r_state <= S_HOLD;
                        r_cnt   <= '0;
                        {r_pll_resetb, r_clk_locked, r_rst_out} <= f_outs(S_HOLD);
                    end
                end
                S_HOLD: begin
                    if (!w_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                        {r_pll_resetb, r_clk_locked, r_rst_out} <= f_outs(S_WAIT_LOCK);
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        {r_pll_resetb, r_clk_locked, r_rst_out} <= f_outs(S_RUN);
                    end
                end
                S_RUN: begin
                    // No timing in RUN; keep the counter parked at zero.
                    r_cnt <= '0;
                    if (!w_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                        {r_pll_resetb, r_clk_locked, r_rst_out} <= f_outs(S_WAIT_LOCK);
                    end
                end
                default: begin
                    r_state <= S_PLL_RST;
                    r_cnt   <= '0;
                    {r_pll_resetb, r_clk_locked, r_rst_out} <= f_outs(S_PLL_RST);
                end
            endcase
        end
    end

    assign pll_resetb = r_pll_resetb;
    assign clk_locked = r_clk_locked;
    assign rst_out    = r_rst_out;

`ifdef CLOCK_LOCK_LOSS_COUNT_EN
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic             w_loss;
    logic             r_lost;
    logic [CNT_W-1:0] r_loss_cnt;

    // A loss is the edge that leaves HOLD/RUN because lock dropped.
    assign w_loss = ((r_state == S_HOLD) || (r_state == S_RUN)) && !w_lock_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lost     <= 1'b0;
            r_loss_cnt <= '0;
        end else if (clear_loss) begin
            // A loss on the clearing edge is counted after the clear.
            r_lost     <= w_loss;
            r_loss_cnt <= w_loss ? CNT_W'(1) : '0;
        end else if (w_loss) begin
            r_lost     <= 1'b1;
            r_loss_cnt <= f_sat_inc(r_loss_cnt);
        end
    end

    assign lost       = r_lost;
    assign loss_count = r_loss_cnt;
`else
    logic w_unused;
    assign w_unused   = clear_loss;
    assign lost       = 1'b0;
    assign loss_count = '0;
`endif

endmodule

// File: tb/tb_clock_lock_supervisor.sv
module tb_clock_lock_supervisor;

    localparam int SYNC  = 2;
    localparam int SETT  = 8;
    localparam int HOLDC = 4;
    localparam int TMO   = 32;
    localparam int PRST  = 3;
    localparam int CNTW  = 2;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic lk_i = 1'b0;
    logic clr_i = 1'b0;
    logic pll_resetb, clk_locked, rst_out, lost;
    logic [CNTW-1:0] loss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_lock_supervisor #(
        .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETT), .RESET_HOLD(HOLDC),
        .TIMEOUT_CYCLES(TMO), .PLL_RST_CYCLES(PRST), .CNT_W(CNTW)
    ) dut (
        .clk(clk), .rst(rst_i), .pll_locked(lk_i), .clear_loss(clr_i),
        .pll_resetb(pll_resetb), .clk_locked(clk_locked), .rst_out(rst_out),
        .lost(lost), .loss_count(loss_count)
    );

    // ---------------- reference model (elapsed-time view) ----------------
    localparam int M_PRST = 0, M_WAIT = 1, M_SETTLE = 2, M_HOLD = 3, M_RUN = 4;
    int   m_mode = M_PRST;
    int   m_t0   = 0;
    int   m_n    = 0;
    logic m_lq[$];
    int   m_cnt  = 0;
    logic m_lost = 1'b0;

    task automatic model_step(input logic r, input logic l, input logic c);
        logic ls;
        int   e;
        int   nm;
        bit   loss;
        m_n++;
        if (r) begin
            m_mode = M_PRST;
            m_t0   = m_n;
            m_lq.delete();
            for (int i = 0; i < SYNC; i++) m_lq.push_back(1'b0);
            m_cnt  = 0;
            m_lost = 1'b0;
            return;
        end
        // The FSM sees the lock sample taken SYNC edges ago.
        ls = m_lq.pop_front();
        m_lq.push_back(l);
        e    = m_n - m_t0;
        nm   = m_mode;
        loss = 0;
        case (m_mode)
            M_PRST:   if (e == PRST) nm = M_WAIT;
            M_WAIT:   if (ls) nm = M_SETTLE; else if (e == TMO) nm = M_PRST;
            M_SETTLE: if (!ls) nm = M_WAIT; else if (e == SETT) nm = M_HOLD;
            M_HOLD:   if (!ls) begin nm = M_WAIT; loss = 1; end
                      else if (e == HOLDC) nm = M_RUN;
            default:  if (!ls) begin nm = M_WAIT; loss = 1; end
        endcase
        if (nm != m_mode) begin
            m_mode = nm;
            m_t0   = m_n;
        end
`ifdef CLOCK_LOCK_LOSS_COUNT_EN
        if (c) begin
            m_cnt  = loss ? 1 : 0;
            m_lost = loss;
        end else if (loss) begin
            m_cnt  = (m_cnt + 1 > (1 << CNTW) - 1) ? (1 << CNTW) - 1 : m_cnt + 1;
            m_lost = 1'b1;
        end
`else
        if (c || loss) begin
            m_cnt  = 0;
            m_lost = 1'b0;
        end
`endif
    endtask

    function automatic logic [5:0] model_out();
        logic pr, cl, ro;
        pr = (m_mode != M_PRST);
        cl = (m_mode == M_HOLD) || (m_mode == M_RUN);
        ro = (m_mode != M_RUN);
        return {pr, cl, ro, m_lost, 2'(m_cnt)};
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [5:0] dut_out();
        return {pll_resetb, clk_locked, rst_out, lost, loss_count};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {resetb,locked,rst_out,lost,cnt}=%b required %b at t=%0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(rst_i, lk_i, clr_i);
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       r;
        logic       l;
        logic       c;
        int         n;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [1:0] satc(input int k);
        return (k > 3) ? 2'd3 : 2'(k);
    endfunction

    task automatic add_row(input logic r, input logic l, input logic c, input int n,
                           input logic pr, input logic cl, input logic ro,
                           input logic ls, input logic [1:0] cnt);
        vec_t v;
        logic       e_ls;
        logic [1:0] e_cnt;
`ifdef CLOCK_LOCK_LOSS_COUNT_EN
        e_ls  = ls;
        e_cnt = cnt;
`else
        e_ls  = 1'b0;
        e_cnt = 2'd0;
`endif
        v.r = r; v.l = l; v.c = c; v.n = n;
        v.exp = {pr, cl, ro, e_ls, e_cnt};
        tbl.push_back(v);
    endtask

    // Drop lock for one cycle while in RUN and re-lock fully.
    task automatic add_loss(input logic clr_on_loss, input logic pl, input logic [1:0] pc,
                            input logic nl, input logic [1:0] nc);
        add_row(0, 0, 0, 1, 1, 1, 0, pl, pc);
        add_row(0, 1, 0, 1, 1, 1, 0, pl, pc);
        add_row(0, 1, clr_on_loss, 1, 1, 0, 1, nl, nc);
        add_row(0, 1, 0, 8, 1, 0, 1, nl, nc);
        add_row(0, 1, 0, 1, 1, 1, 1, nl, nc);
        add_row(0, 1, 0, 4, 1, 1, 0, nl, nc);
    endtask

    initial begin
        for (int i = 0; i < SYNC; i++) m_lq.push_back(1'b0);

        // Reset, then free-running PLL reset / timeout cycle with no lock.
        add_row(1, 0, 0, 2,  0, 0, 1, 0, 0);
        add_row(0, 0, 0, 2,  0, 0, 1, 0, 0);
        add_row(0, 0, 0, 1,  1, 0, 1, 0, 0);
        add_row(0, 0, 0, 31, 1, 0, 1, 0, 0);
        add_row(0, 0, 0, 1,  0, 0, 1, 0, 0);
        add_row(0, 0, 0, 2,  0, 0, 1, 0, 0);
        add_row(0, 0, 0, 1,  1, 0, 1, 0, 0);
        // Lock acquisition: locked at k+10, rst_out falls at k+14.
        add_row(0, 1, 0, 9,  1, 0, 1, 0, 0);
        add_row(0, 1, 0, 1,  1, 0, 1, 0, 0);
        add_row(0, 1, 0, 1,  1, 1, 1, 0, 0);
        add_row(0, 1, 0, 3,  1, 1, 1, 0, 0);
        add_row(0, 1, 0, 1,  1, 1, 0, 0, 0);
        // Four losses in RUN: count 1,2,3,3.
        for (int i = 1; i <= 4; i++)
            add_loss(1'b0, (i > 1), satc(i - 1), 1'b1, satc(i));
        // Clear coincident with a loss leaves count 1, then a lone clear.
        add_loss(1'b1, 1'b1, 2'd3, 1'b1, 2'd1);
        add_row(0, 1, 1, 1,  1, 1, 0, 0, 0);
        // One more loss, then reset while in RUN.
        add_loss(1'b0, 1'b0, 2'd0, 1'b1, 2'd1);
        add_row(1, 1, 0, 1,  0, 0, 1, 0, 0);
        // Lock drops during SETTLE at count 5; full settle restarts.
        add_row(1, 0, 0, 2,  0, 0, 1, 0, 0);
        add_row(0, 0, 0, 2,  0, 0, 1, 0, 0);
        add_row(0, 0, 0, 1,  1, 0, 1, 0, 0);
        add_row(0, 1, 0, 6,  1, 0, 1, 0, 0);
        add_row(0, 0, 0, 3,  1, 0, 1, 0, 0);
        add_row(0, 1, 0, 10, 1, 0, 1, 0, 0);
        add_row(0, 1, 0, 1,  1, 1, 1, 0, 0);

        foreach (tbl[i]) begin
            rst_i = tbl[i].r;
            lk_i  = tbl[i].l;
            clr_i = tbl[i].c;
            for (int j = 0; j < tbl[i].n; j++) step();
            check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // Randomized runs compared cycle by cycle against the model.
        rst_i = 1'b1; lk_i = 1'b0; clr_i = 1'b0;
        step();
        begin
            int cyc;
            cyc = 0;
            while (cyc < 3000) begin
                logic val;
                int   len;
                val = ($urandom_range(0, 3) != 0);
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60)
                                                  : $urandom_range(1, 12);
                for (int j = 0; j < len; j++) begin
                    lk_i  = val;
                    clr_i = ($urandom_range(0, 15) == 0);
                    rst_i = ($urandom_range(0, 499) == 0);
                    step();
                    check("random", dut_out(), model_out());
                    cyc++;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
